// File: rtl/mf_pkg.sv
// Shared widths and state encoding for the minifloat packet accumulator.
package mf_pkg;

   localparam int MF_M_W   = 4;
   localparam int MF_E_W   = 3;
   localparam int MF_VAL_W = 11;
   localparam int MF_SUM_W = 16;
   localparam int MF_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } mf_state_t;

endpackage

// File: rtl/mf_accum_decode.sv
// Minifloat to fixed-point decode: value = mantissa << exponent, 11 bits wide.
module mf_decode
   import mf_pkg::*;
(
   input  logic [MF_M_W-1:0]   in_m,
   input  logic [MF_E_W-1:0]   in_e,
   output logic [MF_VAL_W-1:0] val
);

   logic [MF_VAL_W-1:0] m_ext_s;

   assign m_ext_s = {{(MF_VAL_W-MF_M_W){1'b0}}, in_m};
   assign val     = m_ext_s << in_e;

endmodule

// File: rtl/mf_accum.sv
// Packet accumulator for minifloat beats; optional sum clamping under MF_ACCUM_SAT_EN.
module mf_accum
   import mf_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MF_M_W-1:0]   in_m,
   input  logic [MF_E_W-1:0]   in_e,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [MF_SUM_W-1:0] out_sum,
   output logic [MF_CNT_W-1:0] out_count,
   output logic                out_sat
);

   mf_state_t           state_q, state_d;
   logic [MF_SUM_W-1:0] acc_q, acc_d;
   logic [MF_CNT_W-1:0] cnt_q, cnt_d;
   logic                sat_q, sat_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;

   logic [MF_VAL_W-1:0] beat_val_s;
   logic [MF_SUM_W:0]   sum_ext_s;
   logic                accept_s;

   mf_decode u_decode (
      .in_m (in_m),
      .in_e (in_e),
      .val  (beat_val_s)
   );

   assign accept_s  = in_valid && in_ready_q;
   assign sum_ext_s = {1'b0, acc_q} + {{(MF_SUM_W+1-MF_VAL_W){1'b0}}, beat_val_s};

   // Next-state, accumulate and handshake logic
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               acc_d   = {{(MF_SUM_W-MF_VAL_W){1'b0}}, beat_val_s};
               cnt_d   = {{(MF_CNT_W-1){1'b0}}, 1'b1};
               sat_d   = 1'b0;
               state_d = in_last ? HOLD : ACC;
            end else begin
               state_d = IDLE;
            end
         end
         ACC: begin
            if (accept_s) begin
`ifdef MF_ACCUM_SAT_EN
               if (sum_ext_s[MF_SUM_W]) begin
                  acc_d = {MF_SUM_W{1'b1}};
                  sat_d = 1'b1;
               end else begin
                  acc_d = sum_ext_s[MF_SUM_W-1:0];
               end
`else
               acc_d = sum_ext_s[MF_SUM_W-1:0];
`endif
               if (cnt_q != {MF_CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + {{(MF_CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  cnt_d = cnt_q;
               end
               state_d = in_last ? HOLD : ACC;
            end else begin
               state_d = ACC;
            end
         end
         HOLD: begin
            if (out_valid_q && out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Handshake outputs are registered, so they follow the next state
      in_ready_d  = (state_d != HOLD);
      out_valid_d = (state_d == HOLD);
   end

   // State registers; in_ready stays low while reset is held
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         acc_q       <= {MF_SUM_W{1'b0}};
         cnt_q       <= {MF_CNT_W{1'b0}};
         sat_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = acc_q;
   assign out_count = cnt_q;
   assign out_sat   = sat_q;

endmodule

// File: tb/tb_mf_accum.sv
// Directed self-checking bench for mf_accum; honours MF_ACCUM_SAT_EN when defined.
module tb_mf_accum;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_m;
   logic [2:0]  in_e;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic [7:0]  out_count;
   logic        out_sat;

   int checks = 0;
   int errors = 0;

   mf_accum dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_m      (in_m),
      .in_e      (in_e),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_sat   (out_sat)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_beat(input logic [3:0] m, input logic [2:0] e, input logic last);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_m     = m;
      in_e     = e;
      in_last  = last;
      while (in_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end
      step();
      in_valid = 1'b0;
      in_m     = 4'd0;
      in_e     = 3'd0;
      in_last  = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (out_sum !== 16'd0)      begin errors++; $display("FAIL rst_out_sum: got %0d want 0", out_sum); end
      checks++; if (out_count !== 8'd0)     begin errors++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
      checks++; if (out_sat !== 1'b0)       begin errors++; $display("FAIL rst_out_sat: got %b want 0", out_sat); end
      reset = 1'b0;
      step();
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_single();
      send_beat(4'd9, 3'd3, 1'b1);
      checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
      checks++; if (out_sum !== 16'd72)     begin errors++; $display("FAIL single_sum: got %0d want 72", out_sum); end
      checks++; if (out_count !== 8'd1)     begin errors++; $display("FAIL single_count: got %0d want 1", out_count); end
      checks++; if (out_sat !== 1'b0)       begin errors++; $display("FAIL single_sat: got %b want 0", out_sat); end
      checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL single_ready_hold: got %b want 0", in_ready); end
      consume();
      checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL single_consumed: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL single_ready_after: got %b want 1", in_ready); end
   endtask

   task automatic test_multi();
      send_beat(4'd1, 3'd0, 1'b0);
      checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL multi_early_valid: got %b want 0", out_valid); end
      send_beat(4'd15, 3'd7, 1'b0);
      send_beat(4'd8, 3'd2, 1'b1);
      checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL multi_valid: got %b want 1", out_valid); end
      checks++; if (out_sum !== 16'd1953)   begin errors++; $display("FAIL multi_sum: got %0d want 1953", out_sum); end
      checks++; if (out_count !== 8'd3)     begin errors++; $display("FAIL multi_count: got %0d want 3", out_count); end
      consume();
   endtask

   task automatic test_zero_and_idle_inputs();
      in_valid = 1'b0;
      in_m     = 4'd15;
      in_e     = 3'd7;
      in_last  = 1'b1;
      step();
      step();
      checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL ignore_invalid: got %b want 0", out_valid); end
      send_beat(4'd0, 3'd5, 1'b0);
      send_beat(4'd3, 3'd0, 1'b1);
      checks++; if (out_sum !== 16'd3)      begin errors++; $display("FAIL zero_sum: got %0d want 3", out_sum); end
      checks++; if (out_count !== 8'd2)     begin errors++; $display("FAIL zero_count: got %0d want 2", out_count); end
      consume();
   endtask

   task automatic test_sat();
      for (int i = 0; i < 35; i++) begin
         send_beat(4'd15, 3'd7, (i == 34) ? 1'b1 : 1'b0);
      end
      checks++; if (out_count !== 8'd35)    begin errors++; $display("FAIL sat_count: got %0d want 35", out_count); end
`ifdef MF_ACCUM_SAT_EN
      checks++; if (out_sum !== 16'd65535)  begin errors++; $display("FAIL sat_sum: got %0d want 65535", out_sum); end
      checks++; if (out_sat !== 1'b1)       begin errors++; $display("FAIL sat_flag: got %b want 1", out_sat); end
`else
      checks++; if (out_sum !== 16'd1664)   begin errors++; $display("FAIL wrap_sum: got %0d want 1664", out_sum); end
      checks++; if (out_sat !== 1'b0)       begin errors++; $display("FAIL wrap_flag: got %b want 0", out_sat); end
`endif
      consume();
      send_beat(4'd1, 3'd1, 1'b1);
      checks++; if (out_sat !== 1'b0)       begin errors++; $display("FAIL sat_cleared: got %b want 0", out_sat); end
      checks++; if (out_sum !== 16'd2)      begin errors++; $display("FAIL sat_next_sum: got %0d want 2", out_sum); end
      consume();
   endtask

   task automatic test_count_sat();
      for (int i = 0; i < 300; i++) begin
         send_beat(4'd0, 3'd0, (i == 299) ? 1'b1 : 1'b0);
      end
      checks++; if (out_count !== 8'd255)   begin errors++; $display("FAIL count_sat: got %0d want 255", out_count); end
      checks++; if (out_sum !== 16'd0)      begin errors++; $display("FAIL count_sat_sum: got %0d want 0", out_sum); end
      consume();
   endtask

   task automatic test_backpressure();
      send_beat(4'd2, 3'd2, 1'b1);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 16'd8 || out_count !== 8'd1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: valid=%b sum=%0d count=%0d ready=%b want 1/8/1/0",
                     c, out_valid, out_sum, out_count, in_ready);
         end
         step();
      end
      consume();
      checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL bp_consumed: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL bp_ready_after: got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      send_beat(4'd1, 3'd1, 1'b0);
      in_valid = 1'b1;
      in_m     = 4'd2;
      in_e     = 3'd2;
      in_last  = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
      checks++; if (out_count !== 8'd0)     begin errors++; $display("FAIL mid_rst_count: got %0d want 0", out_count); end
      step();
      in_valid = 1'b0;
      reset    = 1'b0;
      step();
      step();
      checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL mid_rst_no_valid: got %b want 0", out_valid); end
      send_beat(4'd3, 3'd1, 1'b1);
      checks++; if (out_sum !== 16'd6)      begin errors++; $display("FAIL mid_rst_sum: got %0d want 6", out_sum); end
      checks++; if (out_count !== 8'd1)     begin errors++; $display("FAIL mid_rst_count_after: got %0d want 1", out_count); end
      // Reset while a result is pending in HOLD
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL hold_rst_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1;
      in_m     = 4'd1;
      in_e     = 3'd0;
      in_last  = 1'b0;
      step();
      in_m    = 4'd2;
      in_last = 1'b1;
      step();
      checks++; if (out_sum !== 16'd3 || out_count !== 8'd2) begin
         errors++; $display("FAIL b2b_first: sum=%0d count=%0d want 3/2", out_sum, out_count);
      end
      in_m    = 4'd4;
      in_last = 1'b1;
      step();
      step();
      checks++; if (in_ready !== 1'b0 || out_sum !== 16'd3) begin
         errors++; $display("FAIL b2b_stall: ready=%b sum=%0d want 0/3", in_ready, out_sum);
      end
      consume();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_consume: valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_sum !== 16'd4 || out_count !== 8'd1) begin
         errors++; $display("FAIL b2b_second: valid=%b sum=%0d count=%0d want 1/4/1", out_valid, out_sum, out_count);
      end
      consume();
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_m      = 4'd0;
      in_e      = 3'd0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_multi();
      test_zero_and_idle_inputs();
      test_sat();
      test_count_sat();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mf_accum.md
MF_ACCUM -- requirements
Module: mf_accum

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 `clock`  input  1  rising-edge clock for all state.
REQ-003 `reset`  input  1  asynchronous assert, active-high; clears all state.
REQ-004 `in_valid`  input  1  minifloat beat present.
REQ-005 `in_ready`  output  1  block can accept a beat this cycle.
REQ-006 `in_m`  input  4  mantissa of the int2float-stage output.
REQ-007 `in_e`  input  3  exponent of the int2float-stage output.
REQ-008 `in_last`  input  1  final beat of the packet.
REQ-009 `out_valid`  output  1  packet result present.
REQ-010 `out_ready`  input  1  consumer accepts the result.
REQ-011 `out_sum`  output  16  accumulated packet value.
REQ-012 `out_count`  output  8  beats in the packet; saturates at 255.
REQ-013 `out_sat`  output  1  the sum saturated during the packet (0 when MF_ACCUM_SAT_EN is undefined).

Function
REQ-014 Beat value SHALL be computed as in_m << in_e, zero-extended to 11 bits (maximum 15<<7 = 1920).
REQ-015 A beat SHALL transfer when in_valid && in_ready on a rising clock edge.
REQ-016 The state machine SHALL have three states: IDLE, ACC and HOLD.
- IDLE -> ACC on a non-last beat.
- IDLE or ACC -> HOLD on a last beat.
- HOLD -> IDLE on out_valid && out_ready.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, and 0 in HOLD.
REQ-018 In IDLE, the accepted beat value SHALL replace the accumulator (not add to it), and the count SHALL be set to 1.
REQ-019 In ACC, the accepted beat value SHALL be added to the accumulator, and the count SHALL increment, saturating at 255.
REQ-020 out_valid SHALL assert the cycle after the last beat is accepted (latency 1), and SHALL equal (state == HOLD).
REQ-021 out_sum, out_count and out_sat SHALL be registered and held stable while out_valid && !out_ready.
REQ-022 No new beat SHALL be accepted in the cycle the result is consumed; in_ready rises the following cycle.
REQ-023 A single-beat packet (in_last on the first beat) SHALL yield out_count = 1 and out_sum = the beat value.
REQ-024 A zero-valued beat (in_m = 0) SHALL be counted and SHALL contribute 0 to the sum.
REQ-025 in_m, in_e and in_last SHALL be ignored when in_valid = 0.

Reset
REQ-026 Reset SHALL force state IDLE, accumulator 0, count 0 and sat flag 0.
REQ-027 During reset, outputs SHALL be: in_ready 0, out_valid 0, out_sum 0, out_count 0, out_sat 0.
REQ-028 in_ready SHALL be 1 from the first clock edge after reset deasserts.
REQ-029 Reset mid-packet or in HOLD SHALL discard the partial or pending result; no out_valid follows.

Configuration
REQ-030 With MF_ACCUM_SAT_EN defined, an addition whose 17-bit result exceeds 65535 SHALL clamp the sum to 65535 and set the sat flag (sticky until the packet is consumed).
REQ-031 With MF_ACCUM_SAT_EN undefined, the sum SHALL wrap modulo 2^16 and out_sat SHALL be tied to 0.

Structure
REQ-032 Package mf_pkg SHALL hold:
- constants MF_M_W = 4, MF_E_W = 3, MF_VAL_W = 11, MF_SUM_W = 16, MF_CNT_W = 8;
- the state enum type mf_state_t {IDLE, ACC, HOLD}.
REQ-033 Combinational sub-module mf_decode (in_m, in_e -> 11-bit value) SHALL be instantiated once; all state SHALL live in mf_accum.

Verification
REQ-034 One beat m=9, e=3, last=1 -> out_valid next cycle, out_sum = 72, out_count = 1, out_sat = 0.
REQ-035 Beats (1,0), (15,7), (8,2) with last on the third -> out_sum = 1+1920+32 = 1953, out_count = 3.
REQ-036 35 beats of (15,7):
- MF_ACCUM_SAT_EN defined -> out_sum = 65535, out_sat = 1, out_count = 35.
- MF_ACCUM_SAT_EN undefined -> out_sum = 1664 (67200 mod 65536), out_sat = 0.
REQ-037 Backpressure: out_ready held 0 for 5 cycles in HOLD -> outputs stable, in_ready = 0 throughout; result consumed on cycle 6, and in_ready = 1 the next cycle.
REQ-038 Reset during beat 2 of a 4-beat packet, then a fresh single beat (3,1,last) -> out_sum = 6, out_count = 1.
REQ-039 Two packets back to back with in_valid held high -> second packet's first beat accepted only after the first result is consumed; no beat lost or merged.
